// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl: pipeline stall/flush controller (load-use stall when LOAD_USE_STALL_EN is defined)
module mips_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             rs1_d,
  input  logic [4:0]             rs2_d,
  input  logic [4:0]             rsd_e,
  input  logic                   mem_read_e,
  input  logic                   branch_taken_e,
  input  logic                   mem_req_m,
  input  logic                   mem_ack_m,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   stall_e,
  output logic                   stall_m,
  output logic                   flush_d,
  output logic                   flush_e,
  output logic                   flush_w,
  output logic                   bus_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, BUS_ERR} state_t;
  state_t state, state_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic load_use, hold, lu, br;
`ifdef LOAD_USE_STALL_EN
  assign load_use = mem_read_e && rsd_e != 5'd0 && (rsd_e == rs1_d || rsd_e == rs2_d);
`else
  logic unused_load_use;
  assign unused_load_use = ^{mem_read_e, rs1_d, rs2_d, rsd_e};
  assign load_use = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      RUN:
        if (mem_req_m && !mem_ack_m) begin
          state_nx    = MEM_WAIT;
          wait_cnt_nx = 8'd1;
        end
      MEM_WAIT:
        if (mem_ack_m) begin
          state_nx    = RUN;
          wait_cnt_nx = '0;
        end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
          state_nx    = BUS_ERR;
          wait_cnt_nx = '0;
        end else wait_cnt_nx = wait_cnt + 8'd1;
      default: state_nx = RUN;
    endcase
  end
  always_comb begin
    hold    = state == MEM_WAIT ? !mem_ack_m : state == RUN && mem_req_m && !mem_ack_m;
    lu      = state == RUN && !hold && load_use;
    br      = state == RUN && !hold && !load_use && branch_taken_e;
    stall_f = hold || lu;
    stall_d = hold || lu;
    stall_e = hold;
    stall_m = hold;
    flush_d = br;
    flush_e = br || lu;
    flush_w = hold || state == BUS_ERR;
    bus_err = state == BUS_ERR;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (stall_f && !(&stall_cnt)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// tb_mips_hazard_ctrl: directed + random scoreboard bench against a cycle-level reference model
module tb_mips_hazard_ctrl;
  localparam int T = 4;
  localparam int W = 5;
`ifdef LOAD_USE_STALL_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic [4:0] rs1_d, rs2_d, rsd_e;
  logic mem_read_e, branch_taken_e, mem_req_m, mem_ack_m;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, bus_err;
  logic [W-1:0] stall_cnt;
  typedef struct packed {logic [7:0] s; logic [W-1:0] c;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int waited = 0, sc = 0;
  bit err_pend = 1'b0;

  mips_hazard_ctrl #(.MEM_TIMEOUT(T), .STALL_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rsd_e(rsd_e),
    .mem_read_e(mem_read_e), .branch_taken_e(branch_taken_e),
    .mem_req_m(mem_req_m), .mem_ack_m(mem_ack_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w), .bus_err(bus_err),
    .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e   = q.pop_front();
      got = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, bus_err};
      tests++;
      if (got !== e.s) begin
        fails++;
        $display("FAIL strobes t=%0t got %b expected %b (sf sd se sm fd fe fw be)", $time, got, e.s);
      end
      tests++;
      if (stall_cnt !== e.c) begin
        fails++;
        $display("FAIL stall_cnt t=%0t got %0d expected %0d", $time, stall_cnt, e.c);
      end
    end

  // Reference: an access is "waited" for some number of cycles, a timeout leaves one error cycle pending.
  task automatic step(input logic r, input logic [4:0] a, b, d, input logic mr, br, rq, ak);
    logic [7:0] s;
    bit lu;
    @(posedge clk);
    #1;
    rst = r; rs1_d = a; rs2_d = b; rsd_e = d;
    mem_read_e = mr; branch_taken_e = br; mem_req_m = rq; mem_ack_m = ak;
    if (r) begin
      waited = 0; err_pend = 1'b0; sc = 0;
    end
    lu = LU && mr && d != 5'd0 && (d == a || d == b);
    if (err_pend) s = 8'b0000_0011;
    else if (waited > 0) s = ak ? 8'b0 : 8'b1111_0010;
    else if (rq && !ak) s = 8'b1111_0010;
    else if (lu) s = 8'b1100_0100;
    else if (br) s = 8'b0000_1100;
    else s = 8'b0;
    q.push_back({s, W'(sc)});
    if (!r) begin
      if (err_pend) err_pend = 1'b0;
      else if (waited > 0) begin
        if (ak) waited = 0;
        else if (waited == T) begin
          waited = 0;
          err_pend = 1'b1;
        end else waited++;
      end else if (rq && !ak) waited = 1;
      if (s[7] && sc < (1 << W) - 1) sc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; rs1_d = 0; rs2_d = 0; rsd_e = 0;
    mem_read_e = 0; branch_taken_e = 0; mem_req_m = 0; mem_ack_m = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    step(0, 5, 0, 5, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 3, 5, 5, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    for (int i = 0; i < T + 1; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(T + 3);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4);
    idle(2);
    @(posedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_hazard_ctrl.md
# mips_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. Sits beside the forwarding unit and generates per-stage stall and flush strobes for the F/D/E/M/W pipeline registers. Handles three cases: load-to-use bubbles, taken-branch flushes, and wait states from the data-memory bus handshake, including a timeout abort. It also keeps a saturating count of stalled cycles for performance debug.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before abort; legal range 1..255.
- STALL_CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- rs1_d  in  5  source register 1 of the instruction in D.
- rs2_d  in  5  source register 2 of the instruction in D.
- rsd_e  in  5  destination register of the instruction in E.
- mem_read_e  in  1  instruction in E is a load (NEM_LW).
- branch_taken_e  in  1  branch/jump in E resolved taken.
- mem_req_m  in  1  M stage is issuing a data-bus access.
- mem_ack_m  in  1  data bus completes the access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the named pipeline register.
- flush_d, flush_e, flush_w  out  1 each  load a bubble into the named pipeline register.
- bus_err  out  1  one-cycle pulse: the data access timed out.
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with stall_f high.

## Operation
- FSM states: RUN, MEM_WAIT, BUS_ERR. Reset state is RUN.
- RUN, evaluated in priority order:
  1. **Memory wait.** When mem_req_m & !mem_ack_m:
     - assert stall_f, stall_d, stall_e, stall_m and flush_w;
     - go to MEM_WAIT;
     - set the wait counter to 1.
  2. **Load-use** (only with the macro enabled). When mem_read_e & rsd_e != 0 & (rsd_e == rs1_d | rsd_e == rs2_d):
     - assert stall_f, stall_d and flush_e for that cycle;
     - the FSM stays in RUN.
  3. **Taken branch.** When branch_taken_e:
     - assert flush_d and flush_e;
     - stall outputs stay 0.
  4. Otherwise all strobes are 0.
- MEM_WAIT:
  - stall_f, stall_d, stall_e, stall_m and flush_w are held asserted.
  - mem_ack_m=1: drop all strobes in the same cycle, go to RUN and clear the wait counter.
  - Counter == MEM_TIMEOUT and no ack: go to BUS_ERR.
  - Otherwise the counter increments.
  - branch_taken_e is ignored in this state. E is frozen, so the branch is re-evaluated in RUN.
- BUS_ERR (exactly one cycle):
  - bus_err=1 and flush_w=1; all stalls are 0, so the faulting access retires as a bubble;
  - go to RUN unconditionally.
- stall_cnt:
  - increments on every clock where stall_f=1;
  - saturates at all-ones;
  - is cleared only by rst.
- A register index of 0 never causes a load-use stall.

## Timing
- All stall and flush outputs are combinational from the current state and inputs; they take effect at the next clk edge of the pipeline registers.
- Load-use costs exactly 1 bubble. On the next cycle the load is in M and the forwarding unit supplies the data.
- Taken branch costs 2 bubbles (D and E).
- A memory access acked on its first M cycle adds 0 stall cycles.
- An ack after N wait cycles adds N stall cycles.
- Timeout path: MEM_TIMEOUT cycles in MEM_WAIT, plus 1 cycle in BUS_ERR.
- Reset values: state RUN; wait counter 0; stall_cnt 0. All outputs are 0 while rst is high, except combinational strobes in RUN.
- rst asserted mid-MEM_WAIT: the FSM returns to RUN immediately (asynchronously) and the counter clears; no bus_err pulse is generated.
- Simultaneous mem wait and load-use or branch in RUN: memory wait wins. The load-use or branch condition is seen again once the pipeline is released.

## Configuration
- LOAD_USE_STALL_EN
  - Defined: load-use detection as described, inserting 1 bubble.
  - Undefined: no load-use stall is ever generated. The design relies on the forwarding unit's path from data_mem_bus_rd_data_m. The mem_read_e, rs1_d and rs2_d inputs remain on the port list but are unused.

## Test plan
- **Load-use** (LOAD_USE_STALL_EN defined): drive mem_read_e=1, rsd_e=5, rs1_d=5 -> for 1 cycle stall_f=stall_d=flush_e=1, then 0; stall_cnt goes 0->1. Repeat with rsd_e=0 -> no stall.
- **Taken branch**: drive branch_taken_e=1 for one cycle -> flush_d=flush_e=1 for that cycle only; stall_cnt unchanged.
- **Delayed ack**: mem_req_m=1 and ack after 3 cycles -> stall_f/d/e/m and flush_w high for 3 cycles, low in the ack cycle; stall_cnt +3.
- **Timeout** (MEM_TIMEOUT=4): mem_req_m=1, no ack -> 4 cycles in MEM_WAIT, then a 1-cycle bus_err=1 with flush_w=1, then RUN.
- **Priority**: mem wait together with branch_taken_e=1 -> stalls only, no flush_d/flush_e; after the ack the branch flush appears.
- **Reset mid-wait**: assert rst in wait cycle 2 -> all strobes 0 asynchronously, stall_cnt=0, no bus_err afterwards.
